// File: rtl/logic_gates_bist.sv
// logic_gates_bist: sweeps a,b over all four vectors, checks the seven gate outputs against a truth table
module logic_gates_bist #(
  parameter int HOLD_CYCLES = 1,
  parameter int ERR_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             nand_in,
  input  logic             nor_in,
  input  logic             notb_in,
  input  logic             xor_in,
  input  logic             xnor_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec,
  output logic [6:0]       fail_mask
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, APPLY, COMPARE, DONE} state_t;
  state_t         state, state_n;
  logic [1:0]     v;
  logic [HW-1:0]  hold;
  logic           hold_last, accept;
  logic [6:0]     exp_o, act, m;
  logic [2:0]     pc;
  logic [ERR_W+2:0] sum;
  logic [ERR_W-1:0] err_sat;
  assign hold_last = hold == HW'(HOLD_CYCLES - 1);
  assign accept    = (state == IDLE || state == DONE) && start;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      v         <= '0;
      hold      <= '0;
      err_count <= '0;
      fail_vec  <= '0;
      fail_mask <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        v         <= '0;
        hold      <= '0;
        err_count <= '0;
        fail_vec  <= '0;
        fail_mask <= '0;
      end
      if (state == APPLY) hold <= hold_last ? '0 : hold + 1'b1;
      if (state == COMPARE) begin
        fail_mask   <= fail_mask | m;
        fail_vec[v] <= |m;
        err_count   <= err_sat;
        v           <= v + 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: state_n = start ? APPLY : state;
      APPLY:      state_n = hold_last ? COMPARE : APPLY;
      COMPARE:    state_n = (v == 2'd3) ? DONE : APPLY;
      default:    state_n = IDLE;
    endcase
  end
  always_comb begin
    busy  = state == APPLY || state == COMPARE;
    done  = state == DONE;
    pass  = done && err_count == '0;
    a_out = busy & v[1];
    b_out = busy & v[0];
  end
  always_comb begin
    exp_o = {~(a_out ^ b_out), a_out ^ b_out, ~b_out, ~(a_out | b_out),
             ~(a_out & b_out), a_out | b_out, a_out & b_out};
    act   = {xnor_in, xor_in, notb_in, nor_in, nand_in, or_in, and_in};
    m     = exp_o ^ act;
    pc    = '0;
    for (int i = 0; i < 7; i++) pc = pc + {2'b0, m[i]};
    sum     = {3'b0, err_count} + {{ERR_W{1'b0}}, pc};
    err_sat = sum > {3'b0, {ERR_W{1'b1}}} ? '1 : sum[ERR_W-1:0];
  end
endmodule

// File: tb/tb_logic_gates_bist.sv
// tb_logic_gates_bist: fault-injecting gate model around three BIST instances (HOLD 1/ERR 5, HOLD 1/ERR 3, HOLD 3/ERR 5)
module tb_logic_gates_bist;
  logic clk = 0, rst = 1, start = 0;
  logic [6:0]  s0 = '0, s1 = '0;
  logic [27:0] fl = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  s0, s1;
    logic [27:0] fl;
    int          err5, err3;
    logic [3:0]  fv;
    logic [6:0]  fm;
    logic        pass;
  } rec_t;

  function automatic logic [6:0] gold(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  function automatic logic [6:0] fault(input logic a, input logic b, input logic [6:0] z,
                                       input logic [6:0] o, input logic [27:0] f);
    int v = {a, b};
    return ((gold(a, b) & ~z) | o) ^ f[7*v +: 7];
  endfunction

  function automatic rec_t model(input logic [6:0] z, input logic [6:0] o, input logic [27:0] f);
    rec_t r;
    int tot = 0;
    r.s0 = z; r.s1 = o; r.fl = f; r.fv = '0; r.fm = '0;
    for (int v = 0; v < 4; v++) begin
      logic [6:0] g, mm;
      g  = gold(v[1], v[0]);
      mm = g ^ (((g & ~z) | o) ^ f[7*v +: 7]);
      tot += $countones(mm);
      r.fv[v] = |mm;
      r.fm |= mm;
    end
    r.err5 = tot > 31 ? 31 : tot;
    r.err3 = tot > 7 ? 7 : tot;
    r.pass = tot == 0;
    return r;
  endfunction

  logic a1, b1, busy1, done1, pass1;
  logic a2, b2, busy2, done2, pass2;
  logic a3, b3, busy3, done3, pass3;
  logic [4:0] err1, err_h3;
  logic [2:0] err2;
  logic [3:0] fv1, fv2, fv3;
  logic [6:0] fm1, fm2, fm3, g1, g2, g3;
  assign g1 = fault(a1, b1, s0, s1, fl);
  assign g2 = fault(a2, b2, s0, s1, fl);
  assign g3 = fault(a3, b3, s0, s1, fl);

  logic_gates_bist #(.HOLD_CYCLES(1), .ERR_W(5)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a_out(a1), .b_out(b1),
    .and_in(g1[0]), .or_in(g1[1]), .nand_in(g1[2]), .nor_in(g1[3]),
    .notb_in(g1[4]), .xor_in(g1[5]), .xnor_in(g1[6]),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1), .fail_mask(fm1));
  logic_gates_bist #(.HOLD_CYCLES(1), .ERR_W(3)) dut2 (
    .clk(clk), .rst(rst), .start(start), .a_out(a2), .b_out(b2),
    .and_in(g2[0]), .or_in(g2[1]), .nand_in(g2[2]), .nor_in(g2[3]),
    .notb_in(g2[4]), .xor_in(g2[5]), .xnor_in(g2[6]),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2), .fail_mask(fm2));
  logic_gates_bist #(.HOLD_CYCLES(3), .ERR_W(5)) dut3 (
    .clk(clk), .rst(rst), .start(start), .a_out(a3), .b_out(b3),
    .and_in(g3[0]), .or_in(g3[1]), .nand_in(g3[2]), .nor_in(g3[3]),
    .notb_in(g3[4]), .xor_in(g3[5]), .xnor_in(g3[6]),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err_h3), .fail_vec(fv3), .fail_mask(fm3));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run(input rec_t r);
    int n = 0, n1 = 0, n3 = 0;
    @(negedge clk);
    s0 = r.s0; s1 = r.s1; fl = r.fl; start = 1;
    @(posedge clk); #1 start = 0;
    while ((n1 == 0 || n3 == 0) && n < 40) begin
      @(posedge clk); n++; #1;
      if (n < 8) chk("busy_main", busy1, 1);
      if (n < 8) chk("ab_main", {a1, b1}, n / 2);
      if (n < 16) chk("ab_hold3", {a3, b3}, n / 4);
      if (done1 && n1 == 0) n1 = n;
      if (done3 && n3 == 0) n3 = n;
    end
    chk("done_edge_main", n1, 8);
    chk("done_edge_hold3", n3, 16);
    chk("ab_done", {a1, b1, a3, b3}, 0);
    chk("busy_done", busy1, 0);
    chk("err5", err1, r.err5);
    chk("err3", err2, r.err3);
    chk("fail_vec", fv1, r.fv);
    chk("fail_mask", fm1, r.fm);
    chk("pass", pass1, r.pass);
    chk("pass_hold3", pass3, r.pass);
    chk("err_hold3", err_h3, r.err5);
  endtask

  rec_t tbl[7];
  rec_t gold_rec;
  initial begin
    tbl[0] = '{7'h00, 7'h00, 28'h0,       0,  0, 4'h0,    7'h00, 1'b1};
    tbl[1] = '{7'h01, 7'h00, 28'h0,       1,  1, 4'b1000, 7'h01, 1'b0};
    tbl[2] = '{7'h7F, 7'h00, 28'h0,       14, 7, 4'hF,    7'h7F, 1'b0};
    tbl[3] = '{7'h00, 7'h7F, 28'h0,       14, 7, 4'hF,    7'h7F, 1'b0};
    tbl[4] = '{7'h00, 7'h10, 28'h0,       2,  2, 4'b1010, 7'h10, 1'b0};
    tbl[5] = '{7'h00, 7'h00, 28'h0100000, 1,  1, 4'b0100, 7'h40, 1'b0};
    tbl[6] = '{7'h00, 7'h00, 28'hFE00000, 7,  7, 4'b1000, 7'h7F, 1'b0};
    gold_rec = tbl[0];
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {a1, b1, busy1, done1, pass1}, 0);
    chk("rst_results", {err1, fv1, fm1}, 0);
    @(negedge clk) rst = 0;
    foreach (tbl[i]) run(tbl[i]);
    for (int i = 0; i < 12; i++)
      run(model(7'($urandom & $urandom & $urandom), 7'($urandom & $urandom & $urandom),
                28'($urandom & $urandom)));
    run(model(7'h7F, 7'h00, 28'hFFFFFFF));
    // abort mid-run: the edge that samples rst must wipe everything
    @(negedge clk); s0 = 7'h01; start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    chk("abort_outs", {busy1, done1, a1, b1, busy3, a3, b3}, 0);
    chk("abort_results", {err1, fv1, fm1}, 0);
    @(negedge clk) rst = 0;
    run(gold_rec);
    run(tbl[1]);
    // start held high from DONE: restart clears results, mid-run start is ignored
    begin
      int n = 0;
      @(negedge clk); s0 = '0; s1 = '0; fl = '0; start = 1;
      @(posedge clk); #1;
      chk("restart_done_low", done1, 0);
      chk("restart_clear", {err1, fv1, fm1}, 0);
      chk("restart_busy", busy1, 1);
      while (!done1 && n < 40) begin
        @(posedge clk); n++; #1;
      end
      start = 0;
      chk("restart_done_edge", n, 8);
      chk("restart_pass", pass1, 1);
      n = 0;
      while (!done3 && n < 40) begin
        @(posedge clk); n++; #1;
      end
      chk("restart_hold3_done", done3, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
